gpio_cmd_decoder: RTL

- Decodes the 32-bit GPIO output word written by the MicroBlaze into write, start and read commands.
- Sits between the micro's GPIO and the image memory / convolution core: loads the 3 kernel words, latches the image length, streams image words into memory, fires start, and serves result reads.
- Returns status and read data to the micro on the 32-bit GPIO input word.

---
 rtl/gpio_cmd_pkg.sv | 45 ++++
 rtl/gpio_edge_detect.sv | 38 +++
 rtl/gpio_cmd_decoder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_cmd_pkg.sv
// -----------------------------------------------------------------------------
// gpio_cmd_pkg
// Shared definitions for the GPIO command decoder: command codes carried in
// the control field of the micro's GPIO word, decoder state encodings, and
// bit positions of the fields in the incoming command word and the outgoing
// status word.
// -----------------------------------------------------------------------------
package gpio_cmd_pkg;

    // Default geometry; the top module exposes these as parameters.
    localparam int DEF_GPIO_D   = 32;
    localparam int DEF_NB_DATA  = 24;
    localparam int DEF_NB_ADDR  = 10;
    localparam int DEF_N_KWORDS = 3;

    // Control field codes (i_gpio[31:29]).
    localparam logic [2:0] CMD_KERNEL = 3'b000;
    localparam logic [2:0] CMD_LENGTH = 3'b001;
    localparam logic [2:0] CMD_IMAGE  = 3'b010;
    localparam logic [2:0] CMD_READ   = 3'b011;
    localparam logic [2:0] CMD_LAST   = 3'b100;

    // Decoder states; the encoding is visible to the micro in the status word.
    typedef enum logic [1:0] {
        ST_CONFIG  = 2'd0,
        ST_BUSY    = 2'd1,
        ST_READOUT = 2'd2
    } state_e;

    // Command word fields.
    localparam int CW_CTRL_MSB  = 31;
    localparam int CW_CTRL_LSB  = 29;
    localparam int CW_VALID_BIT = 28;
    localparam int CW_DATA_MSB  = 24;
    localparam int CW_DATA_LSB  = 1;
    localparam int CW_SRST_BIT  = 0;

    // Status word fields.
    localparam int SW_RDATA_MSB  = 23;
    localparam int SW_RDFLAG_BIT = 24;
    localparam int SW_STATE_LSB  = 25;
    localparam int SW_ACK_BIT    = 27;
    localparam int SW_ERR_BIT    = 28;

endpackage

// File: rtl/gpio_edge_detect.sv
// -----------------------------------------------------------------------------
// gpio_edge_detect
// Rising-edge detector on a single level input. The history flop loads the
// live input during reset, so a level that is already high when reset is
// released is not reported as an edge.
// Ports:
//   i_clk    - system clock
//   i_reset  - synchronous active-high reset
//   i_d      - level input being watched
//   o_rise   - high in the cycle where i_d is 1 and was 0 on the previous edge
// -----------------------------------------------------------------------------
module gpio_edge_detect (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_rise
);

    logic d_prev_q;
    logic d_prev_d;

    // Next value of the history flop is simply the current input level.
    always_comb begin
        d_prev_d = i_d;
    end

    // History register; reset loads the live input instead of clearing.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            d_prev_q <= i_d;
        end else begin
            d_prev_q <= d_prev_d;
        end
    end

    assign o_rise = i_d & ~d_prev_q;

endmodule

// File: rtl/gpio_cmd_decoder.sv
// -----------------------------------------------------------------------------
// gpio_cmd_decoder
// Turns the MicroBlaze GPIO output word into kernel loads, image length,
// image memory writes, a conv-core start pulse and result reads, and returns
// status plus read data on the GPIO input word.
// Ports:
//   i_CLK, i_reset          - clock, synchronous active-high reset
//   i_gpio                  - command word: [31:29] ctrl, [28] valid,
//                             [24:1] data, [0] soft reset
//   o_gpio                  - status: [23:0] read data, [24] rd_flag,
//                             [26:25] state, [27] ack, [28] err
//   o_kernel_*              - kernel word write port
//   o_img_length            - image length (columns-1)
//   o_mem_*                 - image memory write port
//   o_start                 - one-cycle start to the conv core
//   o_rd_req, o_rd_addr     - result read request
//   i_rd_data, i_rd_valid   - result read return
//   i_conv_done             - conv core finished pulse
//   o_soft_reset            - registered copy of i_gpio[0]
// -----------------------------------------------------------------------------
module gpio_cmd_decoder
    import gpio_cmd_pkg::*;
#(
    parameter int GPIO_D   = DEF_GPIO_D,
    parameter int NB_DATA  = DEF_NB_DATA,
    parameter int NB_ADDR  = DEF_NB_ADDR,
    parameter int N_KWORDS = DEF_N_KWORDS
) (
    input  logic               i_CLK,
    input  logic               i_reset,
    input  logic [GPIO_D-1:0]  i_gpio,
    output logic [GPIO_D-1:0]  o_gpio,
    output logic [NB_DATA-1:0] o_kernel_data,
    output logic               o_kernel_we,
    output logic [1:0]         o_kernel_idx,
    output logic [NB_ADDR-1:0] o_img_length,
    output logic [NB_DATA-1:0] o_mem_wdata,
    output logic               o_mem_we,
    output logic [NB_ADDR-1:0] o_mem_waddr,
    output logic               o_start,
    output logic               o_rd_req,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    input  logic               i_rd_valid,
    input  logic               i_conv_done,
    output logic               o_soft_reset
);

    localparam logic [NB_ADDR-1:0] ADDR_MAX  = {NB_ADDR{1'b1}};
    localparam logic [1:0]         KIDX_LAST = 2'(N_KWORDS - 1);

    // Command word fields.
    logic [2:0]         ctrl;
    logic [NB_DATA-1:0] data;
    logic               srst;
    logic               valid_rise;
    logic [2:0]         unused_gpio_bits;

    assign ctrl             = i_gpio[CW_CTRL_MSB:CW_CTRL_LSB];
    assign data             = i_gpio[CW_DATA_MSB:CW_DATA_LSB];
    assign srst             = i_gpio[CW_SRST_BIT];
    assign unused_gpio_bits = i_gpio[27:25];

    gpio_edge_detect u_valid_edge (
        .i_clk   (i_CLK),
        .i_reset (i_reset),
        .i_d     (i_gpio[CW_VALID_BIT]),
        .o_rise  (valid_rise)
    );

    // Control state.
    state_e             state_q, state_d;
    logic [1:0]         kidx_q, kidx_d;
    logic [NB_ADDR-1:0] waddr_q, waddr_d;
    logic               full_q, full_d;
    logic               err_q, err_d;
    logic [NB_ADDR:0]   nwords_q, nwords_d;
    logic [NB_ADDR-1:0] raddr_q, raddr_d;
    logic               ack_q, ack_d;
    logic               rd_flag_q, rd_flag_d;
    logic [NB_DATA-1:0] rd_data_q, rd_data_d;
    logic               start_pend_q, start_pend_d;

    // Registered outputs.
    logic               soft_reset_q, soft_reset_d;
    logic [NB_ADDR-1:0] img_length_q, img_length_d;
    logic [NB_DATA-1:0] kernel_data_q, kernel_data_d;
    logic               kernel_we_q, kernel_we_d;
    logic [1:0]         kernel_idx_q, kernel_idx_d;
    logic [NB_DATA-1:0] mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic [NB_ADDR-1:0] mem_waddr_q, mem_waddr_d;
    logic               start_q, start_d;
    logic               rd_req_q, rd_req_d;
    logic [NB_ADDR-1:0] rd_addr_q, rd_addr_d;

    // Per-cycle command decisions.
    logic               do_kernel, do_image, do_last, do_read, leave_readout;
    logic [1:0]         kidx_cur;
    logic [NB_ADDR-1:0] waddr_cur;
    logic               full_cur;

    // Command decode and next-state computation for every register.
    always_comb begin
        state_d       = state_q;
        kidx_d        = kidx_q;
        waddr_d       = waddr_q;
        full_d        = full_q;
        err_d         = err_q;
        nwords_d      = nwords_q;
        raddr_d       = raddr_q;
        ack_d         = ack_q;
        rd_flag_d     = rd_flag_q;
        rd_data_d     = rd_data_q;
        start_pend_d  = 1'b0;
        soft_reset_d  = srst;
        img_length_d  = img_length_q;
        kernel_data_d = kernel_data_q;
        kernel_we_d   = 1'b0;
        kernel_idx_d  = kernel_idx_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;
        mem_waddr_d   = mem_waddr_q;
        start_d       = start_pend_q;
        rd_req_d      = 1'b0;
        rd_addr_d     = rd_addr_q;
        do_kernel     = 1'b0;
        do_image      = 1'b0;
        do_last       = 1'b0;
        do_read       = 1'b0;
        leave_readout = 1'b0;
        kidx_cur      = kidx_q;
        waddr_cur     = waddr_q;
        full_cur      = full_q;

        if (srst) begin
            // Soft reset wipes everything the micro sees except the length.
            state_d       = ST_CONFIG;
            kidx_d        = 2'd0;
            waddr_d       = '0;
            full_d        = 1'b0;
            err_d         = 1'b0;
            nwords_d      = '0;
            raddr_d       = '0;
            ack_d         = 1'b0;
            rd_flag_d     = 1'b0;
            rd_data_d     = '0;
            kernel_data_d = '0;
            kernel_idx_d  = 2'd0;
            mem_wdata_d   = '0;
            mem_waddr_d   = '0;
            start_d       = 1'b0;
            rd_addr_d     = '0;
        end else begin
            case (state_q)
                ST_CONFIG: begin
                    if (ctrl == CMD_LENGTH) begin
                        img_length_d = data[NB_ADDR-1:0];
                    end else begin
                        img_length_d = img_length_q;
                    end
                    if (valid_rise) begin
                        case (ctrl)
                            CMD_KERNEL: do_kernel = 1'b1;
                            CMD_IMAGE:  do_image  = 1'b1;
                            CMD_LAST: begin
                                do_image = 1'b1;
                                do_last  = 1'b1;
                            end
                            default: do_kernel = 1'b0;
                        endcase
                    end else begin
                        do_kernel = 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (i_conv_done) begin
                        state_d = ST_READOUT;
                        raddr_d = '0;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
                ST_READOUT: begin
                    if (ctrl == CMD_LENGTH) begin
                        img_length_d = data[NB_ADDR-1:0];
                    end else begin
                        img_length_d = img_length_q;
                    end
                    if (valid_rise) begin
                        case (ctrl)
                            CMD_READ: do_read = 1'b1;
                            CMD_KERNEL: begin
                                leave_readout = 1'b1;
                                do_kernel     = 1'b1;
                            end
                            CMD_IMAGE: begin
                                leave_readout = 1'b1;
                                do_image      = 1'b1;
                            end
                            default: do_read = 1'b0;
                        endcase
                    end else begin
                        do_read = 1'b0;
                    end
                end
                default: state_d = ST_CONFIG;
            endcase

            // Leaving readout restarts the load sequence; the command that
            // caused it then runs against the cleared pointers.
            if (leave_readout) begin
                state_d   = ST_CONFIG;
                kidx_cur  = 2'd0;
                waddr_cur = '0;
                full_cur  = 1'b0;
                kidx_d    = 2'd0;
                waddr_d   = '0;
                full_d    = 1'b0;
            end else begin
                state_d = state_d;
            end

            if (do_kernel) begin
                kernel_we_d   = 1'b1;
                kernel_data_d = data;
                kernel_idx_d  = kidx_cur;
                kidx_d        = (kidx_cur == KIDX_LAST) ? 2'd0 : kidx_cur + 2'd1;
            end else begin
                kernel_we_d = 1'b0;
            end

            // Once the top address has been written the pointer parks there
            // and later writes only raise err.
            if (do_image) begin
                if (full_cur) begin
                    err_d = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = waddr_cur;
                    mem_wdata_d = data;
                    if (waddr_cur == ADDR_MAX) begin
                        full_d  = 1'b1;
                        waddr_d = waddr_cur;
                    end else begin
                        waddr_d = waddr_cur + {{(NB_ADDR-1){1'b0}}, 1'b1};
                    end
                end
            end else begin
                mem_we_d = 1'b0;
            end

            // Start follows the final image write by one cycle.
            if (do_last) begin
                start_pend_d = 1'b1;
                state_d      = ST_BUSY;
                nwords_d     = {1'b0, waddr_cur} + (NB_ADDR+1)'(1);
            end else begin
                start_pend_d = 1'b0;
            end

            if (do_read) begin
                rd_req_d  = 1'b1;
                rd_addr_d = raddr_q;
                rd_flag_d = 1'b0;
                if ({1'b0, raddr_q} == nwords_q - (NB_ADDR+1)'(1)) begin
                    raddr_d = '0;
                end else begin
                    raddr_d = raddr_q + {{(NB_ADDR-1){1'b0}}, 1'b1};
                end
            end else begin
                rd_req_d = 1'b0;
            end

            if (do_kernel || do_image || do_read) begin
                ack_d = ~ack_q;
            end else begin
                ack_d = ack_q;
            end

            // A returning read wins over a same-cycle request clearing the flag.
            if (i_rd_valid) begin
                rd_data_d = i_rd_data;
                rd_flag_d = 1'b1;
            end else begin
                rd_data_d = rd_data_d;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state_q       <= ST_CONFIG;
            kidx_q        <= 2'd0;
            waddr_q       <= '0;
            full_q        <= 1'b0;
            err_q         <= 1'b0;
            nwords_q      <= '0;
            raddr_q       <= '0;
            ack_q         <= 1'b0;
            rd_flag_q     <= 1'b0;
            rd_data_q     <= '0;
            start_pend_q  <= 1'b0;
            soft_reset_q  <= 1'b0;
            img_length_q  <= '0;
            kernel_data_q <= '0;
            kernel_we_q   <= 1'b0;
            kernel_idx_q  <= 2'd0;
            mem_wdata_q   <= '0;
            mem_we_q      <= 1'b0;
            mem_waddr_q   <= '0;
            start_q       <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            kidx_q        <= kidx_d;
            waddr_q       <= waddr_d;
            full_q        <= full_d;
            err_q         <= err_d;
            nwords_q      <= nwords_d;
            raddr_q       <= raddr_d;
            ack_q         <= ack_d;
            rd_flag_q     <= rd_flag_d;
            rd_data_q     <= rd_data_d;
            start_pend_q  <= start_pend_d;
            soft_reset_q  <= soft_reset_d;
            img_length_q  <= img_length_d;
            kernel_data_q <= kernel_data_d;
            kernel_we_q   <= kernel_we_d;
            kernel_idx_q  <= kernel_idx_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
            mem_waddr_q   <= mem_waddr_d;
            start_q       <= start_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign o_gpio        = {3'b000, err_q, ack_q, state_q, rd_flag_q, rd_data_q};
    assign o_kernel_data = kernel_data_q;
    assign o_kernel_we   = kernel_we_q;
    assign o_kernel_idx  = kernel_idx_q;
    assign o_img_length  = img_length_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_waddr   = mem_waddr_q;
    assign o_start       = start_q;
    assign o_rd_req      = rd_req_q;
    assign o_rd_addr     = rd_addr_q;
    assign o_soft_reset  = soft_reset_q;

endmodule
